// File: rtl/pcie_tl_pkg.sv
// rtl/pcie_tl_pkg.sv - shared widths, field positions and pause rule for the VC-to-destination stage
package pcie_tl_pkg;
    localparam int DATA_W     = 6;
    localparam int DEPTH      = 4;
    localparam int PTR_W      = 2;
    localparam int BIT_VC     = 5;
    localparam int BIT_DEST   = 4;
    localparam int UMBRAL_RST = 1;

    // A destination stops accepting words once its free slots drop to the threshold or it is full.
    function automatic logic dest_blocked(input int occ, input int umbral, input int depth);
        return ((depth - occ) <= umbral) || (occ == depth);
    endfunction
endpackage

// File: rtl/arbitro_vc_dest_if.sv
// rtl/arbitro_vc_dest_if.sv - show-ahead head/empty/pop handshake of the two upstream VC FIFOs
interface arbitro_vc_dest_if;
    logic [pcie_tl_pkg::DATA_W-1:0] vc0_data;
    logic                           vc0_empty;
    logic                           vc0_pop;
    logic [pcie_tl_pkg::DATA_W-1:0] vc1_data;
    logic                           vc1_empty;
    logic                           vc1_pop;

    modport master (
        output vc0_data, vc0_empty, vc1_data, vc1_empty,
        input  vc0_pop, vc1_pop
    );

    modport slave (
        input  vc0_data, vc0_empty, vc1_data, vc1_empty,
        output vc0_pop, vc1_pop
    );
endinterface

// File: rtl/fifo_dest.sv
// rtl/fifo_dest.sv - destination FIFO with registered read data, sticky underflow and threshold pause
module fifo_dest
    import pcie_tl_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int DP = DEPTH,
    parameter int PW = PTR_W
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          init_i,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic          pend_i,
    input  logic [PW-1:0] umbral_i,
    output logic [DW-1:0] rd_data_o,
    output logic          empty_o,
    output logic          pausa_o,
    output logic          error_o
);
    logic [DW-1:0] mem_q [DP];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          empty_q, empty_d, pausa_q, pausa_d, error_q, error_d;
    logic          rd_ok, wr_ok;
    logic [PW+1:0] occ_d;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        error_d   = error_q;
        empty_d   = empty_q;
        pausa_d   = 1'b0;
        occ_d     = '0;
        wr_ok     = wr_en_i && !init_i;
        rd_ok     = rd_en_i && (count_q != '0);
        if (init_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            rd_data_d = '0;
            error_d   = 1'b0;
            empty_d   = 1'b1;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_ok) begin
                rd_ptr_d  = rd_ptr_q + 1'b1;
                rd_data_d = mem_q[rd_ptr_q];
            end
            // A read against an empty FIFO fails even when a write lands on the same edge.
            error_d = error_q | (rd_en_i && !rd_ok);
            count_d = count_q + {{PW{1'b0}}, wr_ok} - {{PW{1'b0}}, rd_ok};
            empty_d = (count_d == '0);
            occ_d   = {1'b0, count_d} + {{(PW+1){1'b0}}, pend_i};
            pausa_d = dest_blocked(int'(occ_d), int'(umbral_i), DP);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            empty_q   <= 1'b1;
            pausa_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
            empty_q   <= empty_d;
            pausa_q   <= pausa_d;
            error_q   <= error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_L && wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = rd_data_q;
    assign empty_o   = empty_q;
    assign pausa_o   = pausa_q;
    assign error_o   = error_q;
endmodule

// File: rtl/arbitro_vc_dest.sv
// rtl/arbitro_vc_dest.sv - VC0-priority arbiter routing words by destination bit into two local FIFOs
module arbitro_vc_dest
    import pcie_tl_pkg::*;
(
    input  logic                clk,
    input  logic                reset_L,
    input  logic                init,
    input  logic [PTR_W-1:0]    umbralD0,
    input  logic [PTR_W-1:0]    umbralD1,
    arbitro_vc_dest_if.slave    vc,
    input  logic                pop_D0,
    input  logic                pop_D1,
    output logic [DATA_W-1:0]   data_out0,
    output logic [DATA_W-1:0]   data_out1,
    output logic                empty_D0,
    output logic                empty_D1,
    output logic                pausa_D0,
    output logic                pausa_D1,
    output logic                error_D0,
    output logic                error_D1
);
    logic [PTR_W-1:0]  umbral0_q, umbral0_d, umbral1_q, umbral1_d;
    logic              pend_v_q, pend_v_d;
    logic [DATA_W-1:0] pend_w_q, pend_w_d;
    logic              flush, vc0_ok, vc1_ok, pop0, pop1;
    logic              wr0, wr1, pend_to0_d, pend_to1_d;

    // pausa_Dx holds the blocked state of the current occupancy, so it doubles as the arbiter's gate.
    always_comb begin
        flush      = !reset_L || init;
        umbral0_d  = init ? umbralD0 : umbral0_q;
        umbral1_d  = init ? umbralD1 : umbral1_q;
        vc0_ok     = !vc.vc0_empty && !(vc.vc0_data[BIT_DEST] ? pausa_D1 : pausa_D0);
        vc1_ok     = !vc.vc1_empty && !(vc.vc1_data[BIT_DEST] ? pausa_D1 : pausa_D0);
        pop0       = !flush && vc0_ok;
        pop1       = !flush && !pop0 && vc1_ok;
        pend_v_d   = pop0 || pop1;
        pend_w_d   = pend_w_q;
        if (pop0) pend_w_d = vc.vc0_data;
        else if (pop1) pend_w_d = vc.vc1_data;
        if (flush) begin
            pend_v_d = 1'b0;
            pend_w_d = '0;
        end
        wr0        = pend_v_q && !pend_w_q[BIT_DEST];
        wr1        = pend_v_q &&  pend_w_q[BIT_DEST];
        pend_to0_d = pend_v_d && !pend_w_d[BIT_DEST];
        pend_to1_d = pend_v_d &&  pend_w_d[BIT_DEST];
        vc.vc0_pop = pop0;
        vc.vc1_pop = pop1;
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            umbral0_q <= PTR_W'(UMBRAL_RST);
            umbral1_q <= PTR_W'(UMBRAL_RST);
            pend_v_q  <= 1'b0;
            pend_w_q  <= '0;
        end else begin
            umbral0_q <= umbral0_d;
            umbral1_q <= umbral1_d;
            pend_v_q  <= pend_v_d;
            pend_w_q  <= pend_w_d;
        end
    end

    fifo_dest #(.DW(DATA_W), .DP(DEPTH), .PW(PTR_W)) u_d0 (
        .clk       (clk),
        .reset_L   (reset_L),
        .init_i    (init),
        .wr_en_i   (wr0),
        .wr_data_i (pend_w_q),
        .rd_en_i   (pop_D0),
        .pend_i    (pend_to0_d),
        .umbral_i  (umbral0_q),
        .rd_data_o (data_out0),
        .empty_o   (empty_D0),
        .pausa_o   (pausa_D0),
        .error_o   (error_D0)
    );

    fifo_dest #(.DW(DATA_W), .DP(DEPTH), .PW(PTR_W)) u_d1 (
        .clk       (clk),
        .reset_L   (reset_L),
        .init_i    (init),
        .wr_en_i   (wr1),
        .wr_data_i (pend_w_q),
        .rd_en_i   (pop_D1),
        .pend_i    (pend_to1_d),
        .umbral_i  (umbral1_q),
        .rd_data_o (data_out1),
        .empty_o   (empty_D1),
        .pausa_o   (pausa_D1),
        .error_o   (error_D1)
    );
endmodule

// File: doc/arbitro_vc_dest.md
Name: arbitro_vc_dest

Overview:
- Downstream stage of the VC0/VC1 virtual-channel FIFOs in the PCIe transaction path.
- Pops words from the two VC FIFOs, VC0 having priority over VC1.
- Routes each word by its destination bit into one of two local destination FIFOs (D0, D1). Those FIFOs drive data_out0/data_out1 to the consumer.
- Generates per-destination pause flags from programmable thresholds and flags underflow errors.

Parameters:
- DATA_W, 6, word width: bit5 = VC id, bit4 = destination (0→D0, 1→D1), bits3:0 = payload.
- DEPTH, 4, entries per destination FIFO (power of 2).
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  single clock, rising edge.
- reset_L  in  1  synchronous, active-low reset.
- init  in  1  high: flush D FIFOs, latch thresholds, block all pops.
- umbralD0  in  PTR_W  D0 pause threshold (free slots), sampled only while init=1.
- umbralD1  in  PTR_W  D1 pause threshold, sampled only while init=1.
- vc0_data  in  DATA_W  VC0 FIFO head word (show-ahead, valid when vc0_empty=0).
- vc0_empty  in  1  VC0 FIFO empty.
- vc1_data  in  DATA_W  VC1 FIFO head word.
- vc1_empty  in  1  VC1 FIFO empty.
- vc0_pop  out  1  pop VC0 this cycle (combinational).
- vc1_pop  out  1  pop VC1 this cycle (combinational).
- pop_D0  in  1  consumer read request, D0.
- pop_D1  in  1  consumer read request, D1.
- data_out0  out  DATA_W  registered D0 read data.
- data_out1  out  DATA_W  registered D1 read data.
- empty_D0  out  1  D0 empty.
- empty_D1  out  1  D1 empty.
- pausa_D0  out  1  D0 almost full.
- pausa_D1  out  1  D1 almost full.
- error_D0  out  1  sticky: pop while D0 empty.
- error_D1  out  1  sticky: pop while D1 empty.

Behaviour:
- Reset (reset_L=0 at clk edge):
  - pointers, counts, data_out0/1, pending-push register and error flags all 0.
  - umbral registers set to 1.
  - empty_Dx=1; pausa_Dx=0; vcX_pop=0.
- Init (init=1, reset_L=1):
  - same flush as reset, except the umbral registers load umbralD0/umbralD1.
  - vc0_pop=vc1_pop=0.
- Effective occupancy of Dx: occ_x = count_x + (pending push targeting x ? 1 : 0).
- Blocking: Dx is blocked when DEPTH - occ_x <= umbral_x or occ_x == DEPTH.
- pausa_Dx: registered, = blocked_x evaluated on next-state values.
- Arbitration (combinational, outside init/reset):
  - vc0_pop=1 if !vc0_empty and destination vc0_data[4] not blocked.
  - Otherwise vc1_pop=1 if !vc1_empty and destination vc1_data[4] not blocked.
  - At most one pop per cycle.
  - No head-of-line blocking across VCs: a blocked VC0 head does not stall VC1.
- Pipeline: the popped word is captured in a pending-push register (data plus valid) and written into its destination FIFO on the next edge. Arbiter pop → FIFO write latency is 1 cycle; word unchanged.
- Dx write/read:
  - Write at wr_ptr, wrapping modulo DEPTH.
  - pop_Dx with count>0: data_out_x <= mem[rd_ptr] at the edge, so data is visible one cycle after pop. rd_ptr wraps.
  - Simultaneous write and read on the same FIFO: count unchanged; allowed at any occupancy, including empty (write lands, read sees old state → underflow).
- Underflow: pop_Dx while count_x==0 leaves data_out_x and pointers unchanged and sets error_Dx=1, held until reset or init.
- Overflow: impossible by construction. The bench asserts count_x never exceeds DEPTH.
- empty_Dx = (count_x==0), registered.
- Reset or init mid-operation: the pending word is discarded; contents are lost.

Decomposition:
- Package pcie_tl_pkg:
  - DATA_W, DEPTH, PTR_W.
  - Field positions BIT_VC=5, BIT_DEST=4.
  - Reset umbral value UMBRAL_RST=1.
- Sub-module fifo_dest:
  - Parameterized FIFO: sync reset/flush, registered read data, count, empty, underflow error, pausa from threshold input and external pending input.
  - Instantiated twice (D0, D1).
  - The top holds the arbiter and the pending register.

Test Plan:
- Reset then init with umbralD0=1, umbralD1=2 → empty_D0/D1=1, pausa=0, error=0, data_out0/1=0, no pops during init.
- VC0 holds 6'b011011, 6'b000011; VC1 empty → vc0_pop on two consecutive cycles.
  - D1 count=1 and D0 count=1 one cycle after each pop.
  - pop_D1 → data_out1=6'b011011 next cycle.
- Both VCs non-empty, VC0 head 6'b001001 (D0), VC1 head 6'b101101 (D0) → VC0 is served first, VC1 the cycle after.
- Fill D0 with umbralD0=1 and no consumer pops → pops stop when occ_D0=3; pausa_D0=1. A VC1 head 6'b111011 (D1) still drains to D1.
- pop_D0 on empty D0 → error_D0=1 and stays 1; data_out0 unchanged. Next init clears it.
- Simultaneous push and pop on D1 at count=2 → count stays 2; read data correct; 8 writes total verify pointer wrap.
